// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, FSM encoding and sizing helper for the nibble-serial adder
package cla_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nibbles(input int width);
      return width / NIB_W;
   endfunction

endpackage

// File: rtl/cla_nibble_serial_adder_if.sv
// cla_nibble_serial_adder_if: operand/result valid-ready bus of the nibble-serial adder
interface cla_nibble_serial_adder_if #(parameter int WIDTH = 16);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;

   modport master (
      output in_valid, a, b, c_in, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf
   );

   modport slave (
      input  in_valid, a, b, c_in, out_ready,
      output in_ready, out_valid, sum, c_out, ovf
   );

endinterface

// File: rtl/cla_4bit_slice.sv
// cla_4bit_slice: combinational 4-bit augmented carry-lookahead slice with group P/G
module cla_4bit_slice
   import cla_pkg::*;
(
   input  logic [NIB_W-1:0] A,
   input  logic [NIB_W-1:0] B,
   input  logic             c_in,
   output logic [NIB_W-1:0] S,
   output logic             P_prop,
   output logic             G_prop
);

   logic [NIB_W-1:0] p;
   logic [NIB_W-1:0] g;
   logic [NIB_W-1:0] c;

   // bit propagate/generate, internal lookahead carries and group terms
   always_comb begin
      p = A ^ B;
      g = A & B;
      c[0] = c_in;
      c[1] = g[0] | (p[0] & c_in);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
      S = p ^ c;
      P_prop = &p;
      G_prop = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   end

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: WIDTH-bit adder that reuses one CLA slice over WIDTH/4 clocks, LSB nibble first
module cla_nibble_serial_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   cla_nibble_serial_adder_if.slave  bus
);

   localparam int NIBBLES = nibbles(WIDTH);
   localparam int CW      = $clog2(NIBBLES);

   if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
   end

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_r;
   logic             carry;
   logic             a_msb;
   logic             b_msb;
   logic [NIB_W-1:0] s_nib;
   logic             p_prop;
   logic             g_prop;
   logic             last;
   logic             accept;

   cla_4bit_slice u_slice (
      .A      (a_sh[NIB_W-1:0]),
      .B      (b_sh[NIB_W-1:0]),
      .c_in   (carry),
      .S      (s_nib),
      .P_prop (p_prop),
      .G_prop (g_prop)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next state and handshake/result outputs; ovf uses the MSBs latched at accept
   always_comb begin
      last          = cnt == CW'(NIBBLES - 1);
      accept        = (state == IDLE) && bus.in_valid;
      state_nx      = accept                                 ? RUN  :
                      (state == RUN && last)                 ? DONE :
                      (state == DONE && bus.out_ready)       ? IDLE : state;
      bus.in_ready  = state == IDLE;
      bus.out_valid = state == DONE;
      bus.sum       = sum_r;
      bus.c_out     = carry;
      bus.ovf       = (a_msb == b_msb) && (sum_r[WIDTH-1] != a_msb);
   end

   // operand capture at accept, then one slice pass per RUN cycle with the carry registered between nibbles
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         a_sh  <= '0;
         b_sh  <= '0;
         sum_r <= '0;
         carry <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
      end else if (accept) begin
         cnt   <= '0;
         a_sh  <= bus.a;
         b_sh  <= bus.b;
         carry <= bus.c_in;
         a_msb <= bus.a[WIDTH-1];
         b_msb <= bus.b[WIDTH-1];
      end else if (state == RUN) begin
         sum_r[NIB_W*cnt +: NIB_W] <= s_nib;
         carry <= g_prop | (p_prop & carry);
         a_sh  <= a_sh >> NIB_W;
         b_sh  <= b_sh >> NIB_W;
         cnt   <= cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb_cla_nibble_serial_adder: directed and randomised checks of the nibble-serial adder at WIDTH=16
module tb_cla_nibble_serial_adder;
   import cla_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   cla_nibble_serial_adder_if #(.WIDTH(16)) bus();

   cla_nibble_serial_adder #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // presents operands until the edge that accepts them; ok=0 if never accepted
   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c, output bit ok);
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.a = x;
      bus.b = y;
      bus.c_in = c;
      for (int n = 0; n < 50 && !ok; n++) begin
         ok = bus.in_ready;
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic take();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.c_in = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
      total++; if (bus.sum !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h exp=0000", bus.sum); end
      total++; if (bus.c_out !== 1'b0) begin bad++; $display("FAIL reset_c_out got=%0b exp=0", bus.c_out); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf); end
   endtask

   task automatic test_basic();
      bit ok;
      int n;
      send(16'h1234, 16'h4321, 1'b0, ok);
      total++; if (!ok) begin bad++; $display("FAIL basic_accept got=0 exp=1"); end
      wait_valid(n);
      // out_valid is first seen high ahead of edge accept+5, the earliest edge that can hand the result over
      total++; if (n + 1 !== 5) begin bad++; $display("FAIL basic_latency got=%0d exp=5", n + 1); end
      total++; if (bus.sum !== 16'h5555) begin bad++; $display("FAIL basic_sum got=%h exp=5555", bus.sum); end
      total++; if (bus.c_out !== 1'b0) begin bad++; $display("FAIL basic_c_out got=%0b exp=0", bus.c_out); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%0b exp=0", bus.ovf); end
      take();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_out_drop got=%0b exp=0", bus.out_valid); end
   endtask

   task automatic test_carry_ripple();
      logic [15:0] xs [2] = '{16'hFFFF, 16'hFFFF};
      logic [15:0] ys [2] = '{16'h0001, 16'h0000};
      logic        cs [2] = '{1'b0, 1'b1};
      bit ok;
      int n;
      for (int i = 0; i < 2; i++) begin
         send(xs[i], ys[i], cs[i], ok);
         wait_valid(n);
         total++; if (n >= 50) begin bad++; $display("FAIL ripple%0d_timeout got=no_out_valid exp=out_valid", i); end
         total++; if (bus.sum !== 16'h0000) begin bad++; $display("FAIL ripple%0d_sum got=%h exp=0000", i, bus.sum); end
         total++; if (bus.c_out !== 1'b1) begin bad++; $display("FAIL ripple%0d_c_out got=%0b exp=1", i, bus.c_out); end
         total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL ripple%0d_ovf got=%0b exp=0", i, bus.ovf); end
         take();
      end
   endtask

   task automatic test_overflow();
      logic [15:0] xs [2] = '{16'h7FFF, 16'h8000};
      logic [15:0] ys [2] = '{16'h0001, 16'h8000};
      logic [15:0] es [2] = '{16'h8000, 16'h0000};
      logic        ec [2] = '{1'b0, 1'b1};
      bit ok;
      int n;
      for (int i = 0; i < 2; i++) begin
         send(xs[i], ys[i], 1'b0, ok);
         wait_valid(n);
         total++; if (bus.sum !== es[i]) begin bad++; $display("FAIL ovf%0d_sum got=%h exp=%h", i, bus.sum, es[i]); end
         total++; if (bus.c_out !== ec[i]) begin bad++; $display("FAIL ovf%0d_c_out got=%0b exp=%0b", i, bus.c_out, ec[i]); end
         total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf%0d_ovf got=%0b exp=1", i, bus.ovf); end
         take();
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int n;
      send(16'h1111, 16'h2222, 1'b1, ok);
      wait_valid(n);
      bus.in_valid = 1'b1;
      bus.a = 16'h0001;
      bus.b = 16'h0002;
      bus.c_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d_out_valid got=%0b exp=1", i, bus.out_valid); end
         total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d_in_ready got=%0b exp=0", i, bus.in_ready); end
         total++; if ({bus.c_out, bus.ovf, bus.sum} !== {1'b0, 1'b0, 16'h3334}) begin
            bad++; $display("FAIL bp_hold%0d_result got=%0b/%0b/%h exp=0/0/3334", i, bus.c_out, bus.ovf, bus.sum);
         end
      end
      take();
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_in_ready got=%0b exp=1", bus.in_ready); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle_out_valid got=%0b exp=0", bus.out_valid); end
      tick();
      bus.in_valid = 1'b0;
      bus.a = 16'hDEAD;
      bus.b = 16'hBEEF;
      bus.c_in = 1'b1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept got=%0b exp=0", bus.in_ready); end
      wait_valid(n);
      total++; if (bus.sum !== 16'h0003) begin bad++; $display("FAIL bp_second_sum got=%h exp=0003", bus.sum); end
      take();
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen;
      int n;
      send(16'hFFFF, 16'hFFFF, 1'b1, ok);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (dut.state !== IDLE) begin bad++; $display("FAIL mid_state got=%0d exp=0", dut.state); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%0b exp=0", bus.out_valid); end
      total++; if (bus.sum !== 16'h0000) begin bad++; $display("FAIL mid_sum got=%h exp=0000", bus.sum); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%0b exp=1", bus.in_ready); end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen |= bus.out_valid;
      end
      total++; if (seen) begin bad++; $display("FAIL mid_no_result got=out_valid exp=none"); end
      send(16'h0F0F, 16'h00F1, 1'b0, ok);
      wait_valid(n);
      total++; if (bus.sum !== 16'h1000) begin bad++; $display("FAIL mid_next_sum got=%h exp=1000", bus.sum); end
      total++; if (bus.c_out !== 1'b0) begin bad++; $display("FAIL mid_next_c_out got=%0b exp=0", bus.c_out); end
      take();
   endtask

   task automatic test_random();
      bit ok;
      int n;
      int accepted = 0;
      int results = 0;
      logic [15:0] x;
      logic [15:0] y;
      logic        c;
      logic [16:0] e;
      logic        eo;
      for (int i = 0; i < 1000; i++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         c = 1'($urandom);
         e = {1'b0, x} + {1'b0, y} + {16'b0, c};
         eo = (x[15] == y[15]) && (e[15] != x[15]);
         repeat ($urandom_range(0, 2)) tick();
         send(x, y, c, ok);
         total++; if (!ok) begin bad++; $display("FAIL rnd%0d_accept got=0 exp=1", i); continue; end
         accepted++;
         bus.a = 16'($urandom);
         bus.b = 16'($urandom);
         bus.c_in = 1'($urandom);
         wait_valid(n);
         total++; if (n >= 50) begin bad++; $display("FAIL rnd%0d_timeout got=no_out_valid exp=out_valid", i); continue; end
         repeat ($urandom_range(0, 3)) tick();
         total++; if ({bus.c_out, bus.sum} !== e) begin bad++; $display("FAIL rnd%0d_sum a=%h b=%h c=%0b got=%h exp=%h", i, x, y, c, {bus.c_out, bus.sum}, e); end
         total++; if (bus.ovf !== eo) begin bad++; $display("FAIL rnd%0d_ovf got=%0b exp=%0b", i, bus.ovf, eo); end
         take();
         results++;
         total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rnd%0d_single_result got=%0b exp=0", i, bus.out_valid); end
      end
      total++; if (results !== accepted) begin bad++; $display("FAIL rnd_result_count got=%0d exp=%0d", results, accepted); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry_ripple();
      test_overflow();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
